// File: rtl/perceptron_trainer_if.sv
// Bundles the loader, run-control and perceptron forward/backward channels of
// the training sequencer. The trainer uses 'master'; host and perceptron use 'slave'.
interface perceptron_trainer_if #(
  parameter int ARGN      = 2,
  parameter int ARG_WIDTH = 8,
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16,
  parameter int FBK_WIDTH = 16,
  parameter int SAMPLES   = 4
);
  localparam int IDX_WIDTH = $clog2(SAMPLES);

  logic                        ld_valid;
  logic                        ld_ready;
  logic [IDX_WIDTH-1:0]        ld_addr;
  logic [ARGN*ARG_WIDTH-1:0]   ld_arg;
  logic [RES_WIDTH-1:0]        ld_tgt;

  logic                        start;
  logic                        busy;
  logic                        done;
  logic [IDX_WIDTH:0]          mismatches;
  logic                        en;

  logic                        arg_valid;
  logic                        arg_ready;
  logic [ARGN*ARG_WIDTH-1:0]   arg_data;

  logic                        res_valid;
  logic                        res_ready;
  logic [RES_WIDTH-1:0]        res_data;

  logic                        err_valid;
  logic                        err_ready;
  logic [ERR_WIDTH-1:0]        err_data;

  logic                        fbk_valid;
  logic                        fbk_ready;
  logic [ARGN*FBK_WIDTH-1:0]   fbk_data;

  modport master (
    input  ld_valid, ld_addr, ld_arg, ld_tgt, start,
    input  arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data,
    output ld_ready, busy, done, mismatches, en,
    output arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready
  );

  modport slave (
    output ld_valid, ld_addr, ld_arg, ld_tgt, start,
    output arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data,
    input  ld_ready, busy, done, mismatches, en,
    input  arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Training sequencer: runs EPOCHS learning passes over a loaded sample table
// through a perceptron, then one evaluation pass that counts result mismatches.
module perceptron_trainer #(
  parameter int ARGN      = 2,
  parameter int ARG_WIDTH = 8,
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16,
  parameter int FBK_WIDTH = 16,
  parameter int SAMPLES   = 4,
  parameter int EPOCHS    = 10
) (
  input logic                 clk,
  input logic                 rst,
  perceptron_trainer_if.master bus
);
  localparam int IDX_WIDTH   = $clog2(SAMPLES);
  localparam int EPOCH_WIDTH = $clog2(EPOCHS) + 1;
  localparam int MIS_WIDTH   = IDX_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, FWD, RES, BWD, FBK, EVAL_FWD, EVAL_RES, DONE
  } state_t;

  state_t state, state_next;

  logic [ARGN*ARG_WIDTH-1:0] tbl_arg [SAMPLES];
  logic [RES_WIDTH-1:0]      tbl_tgt [SAMPLES];

  logic [IDX_WIDTH-1:0]   idx;
  logic [EPOCH_WIDTH-1:0] epoch;
  logic [MIS_WIDTH-1:0]   mis_count;
  logic                   en_q;
  logic [ERR_WIDTH-1:0]   err_q;

  logic arg_valid_c, res_ready_c, err_valid_c, fbk_ready_c;
  logic busy_c, done_c, ld_ready_c;
  logic start_accept, res_fire, fbk_fire;
  logic last_sample, last_epoch;

  logic [RES_WIDTH-1:0]     tgt_cur;
  logic signed [RES_WIDTH:0] diff;

  assign tgt_cur     = tbl_tgt[idx];
  assign last_sample = (idx == IDX_WIDTH'(SAMPLES - 1));
  assign last_epoch  = (epoch == EPOCH_WIDTH'(EPOCHS - 1));
  assign diff        = $signed({1'b0, tgt_cur}) - $signed({1'b0, bus.res_data});

  assign start_accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign res_fire     = res_ready_c && bus.res_valid;
  assign fbk_fire     = fbk_ready_c && bus.fbk_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    arg_valid_c = 1'b0;
    res_ready_c = 1'b0;
    err_valid_c = 1'b0;
    fbk_ready_c = 1'b0;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    ld_ready_c  = 1'b0;
    case (state)
      IDLE: begin
        busy_c     = 1'b0;
        ld_ready_c = 1'b1;
        if (bus.start) state_next = FWD;
      end
      FWD: begin
        arg_valid_c = 1'b1;
        if (bus.arg_ready) state_next = RES;
      end
      RES: begin
        res_ready_c = 1'b1;
        if (bus.res_valid) state_next = BWD;
      end
      BWD: begin
        err_valid_c = 1'b1;
        if (bus.err_ready) state_next = FBK;
      end
      FBK: begin
        fbk_ready_c = 1'b1;
        if (bus.fbk_valid) state_next = (last_sample && last_epoch) ? EVAL_FWD : FWD;
      end
      EVAL_FWD: begin
        arg_valid_c = 1'b1;
        if (bus.arg_ready) state_next = EVAL_RES;
      end
      EVAL_RES: begin
        res_ready_c = 1'b1;
        if (bus.res_valid) state_next = last_sample ? DONE : EVAL_FWD;
      end
      DONE: begin
        busy_c     = 1'b0;
        done_c     = 1'b1;
        ld_ready_c = 1'b1;
        if (bus.start) state_next = FWD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample table has no reset so a reset mid-run keeps the loaded training set.
  always_ff @(posedge clk) begin
    if (bus.ld_valid && ld_ready_c) begin
      tbl_arg[bus.ld_addr] <= bus.ld_arg;
      tbl_tgt[bus.ld_addr] <= bus.ld_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      epoch     <= '0;
      mis_count <= '0;
      en_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      if (start_accept) begin
        idx       <= '0;
        epoch     <= '0;
        mis_count <= '0;
        en_q      <= 1'b1;
      end
      if ((state == RES) && res_fire) err_q <= ERR_WIDTH'(diff);
      if ((state == FBK) && fbk_fire) begin
        idx <= idx + 1'b1;
        if (last_sample) begin
          epoch <= epoch + 1'b1;
          if (last_epoch) en_q <= 1'b0;
        end
      end
      // Evaluation stops on the last index so idx is not advanced past it.
      if ((state == EVAL_RES) && res_fire) begin
        if (bus.res_data != tgt_cur) mis_count <= mis_count + 1'b1;
        if (!last_sample) idx <= idx + 1'b1;
      end
    end
  end

  assign bus.ld_ready   = ld_ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.mismatches = mis_count;
  assign bus.en         = en_q;
  assign bus.arg_valid  = arg_valid_c;
  assign bus.arg_data   = arg_valid_c ? tbl_arg[idx] : '0;
  assign bus.res_ready  = res_ready_c;
  assign bus.err_valid  = err_valid_c;
  assign bus.err_data   = err_q;
  assign bus.fbk_ready  = fbk_ready_c;
endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: a behavioural perceptron responds on both
// channels while directed runs check training, evaluation, stalls and reset.
module tb_perceptron_trainer;
  localparam int ARGN = 2, ARG_WIDTH = 8, RES_WIDTH = 8, ERR_WIDTH = 16, FBK_WIDTH = 16;
  localparam int SAMPLES = 4, EPOCHS = 10;
  localparam int TRAIN_ARGS = SAMPLES * EPOCHS;
  localparam int TOTAL_ARGS = SAMPLES * (EPOCHS + 1);
  localparam int RUN_CYCLES = 4 * SAMPLES * EPOCHS + 2 * SAMPLES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perceptron_trainer_if #(.ARGN(ARGN), .ARG_WIDTH(ARG_WIDTH), .RES_WIDTH(RES_WIDTH),
    .ERR_WIDTH(ERR_WIDTH), .FBK_WIDTH(FBK_WIDTH), .SAMPLES(SAMPLES)) bus ();

  perceptron_trainer #(.ARGN(ARGN), .ARG_WIDTH(ARG_WIDTH), .RES_WIDTH(RES_WIDTH),
    .ERR_WIDTH(ERR_WIDTH), .FBK_WIDTH(FBK_WIDTH), .SAMPLES(SAMPLES), .EPOCHS(EPOCHS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0, fails = 0;
  logic [15:0] tb_arg [SAMPLES];
  logic [7:0]  tb_tgt [SAMPLES];
  logic [15:0] sb [$];

  int arg_count, err_count, exp_mis, stall_pct, cycles;
  int w0, w1, bias, x0, x1, sum, e, delta;
  bit have_res, have_fbk, const_mode, in_eval;
  bit arg_hold, err_hold, saw_ff01, saw_00ff, saw_zero;
  logic [15:0] arg_prev, err_prev, exp_err;
  logic [7:0]  res_hold, cur_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit stall();
    return (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
  endfunction

  task automatic tick_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic model_clear();
    have_res = 0; have_fbk = 0; arg_hold = 0; err_hold = 0;
    bus.res_valid = 1'b0; bus.fbk_valid = 1'b0;
    sb.delete();
    arg_count = 0; err_count = 0; exp_mis = 0;
    w0 = 0; w1 = 0; bias = 0; in_eval = 0;
    saw_ff01 = 0; saw_00ff = 0; saw_zero = 0;
  endtask

  task automatic load(input int a, input logic [15:0] arg, input logic [7:0] tgt);
    int n;
    bus.ld_valid = 1'b1; bus.ld_addr = 2'(a); bus.ld_arg = arg; bus.ld_tgt = tgt;
    n = 0;
    while (bus.ld_ready !== 1'b1 && n < 20) begin tick_neg(); n++; end
    check("ld_ready", bus.ld_ready, 1);
    tick_neg();
    bus.ld_valid = 1'b0;
    tb_arg[a] = arg; tb_tgt[a] = tgt;
  endtask

  task automatic kick_start();
    bus.start = 1'b1;
    tick_neg();
    bus.start = 1'b0;
    check("start_arg_valid", bus.arg_valid, 1);
    check("start_busy", bus.busy, 1);
    check("start_done", bus.done, 0);
    check("start_en", bus.en, 1);
  endtask

  task automatic wait_done(input int limit);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < limit) begin tick_neg(); cycles++; end
    check("done", bus.done, 1);
    check("done_busy", bus.busy, 0);
    check("arg_total", arg_count, TOTAL_ARGS);
    check("err_total", err_count, TRAIN_ARGS);
    check("mismatches", bus.mismatches, exp_mis);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_mis"}, bus.mismatches, 0);
    check({tag, "_en"}, bus.en, 0);
    check({tag, "_arg_valid"}, bus.arg_valid, 0);
    check({tag, "_res_ready"}, bus.res_ready, 0);
    check({tag, "_err_valid"}, bus.err_valid, 0);
    check({tag, "_fbk_ready"}, bus.fbk_ready, 0);
    check({tag, "_arg_data"}, bus.arg_data, 0);
    check({tag, "_err_data"}, bus.err_data, 0);
  endtask

  // Behavioural perceptron: sign-step neuron on the argument MSBs, trained by err sign.
  task automatic model_step();
    int k;
    @(negedge clk);
    if (arg_hold) begin
      check("arg_hold_valid", bus.arg_valid, 1);
      check("arg_hold_data", bus.arg_data, arg_prev);
    end
    if (err_hold) begin
      check("err_hold_valid", bus.err_valid, 1);
      check("err_hold_data", bus.err_data, err_prev);
    end
    bus.arg_ready = !stall();
    bus.err_ready = !stall();
    if (!have_res) bus.res_valid = 1'b0;
    else if (!bus.res_valid && !stall()) begin bus.res_valid = 1'b1; bus.res_data = res_hold; end
    if (!have_fbk) bus.fbk_valid = 1'b0;
    else if (!bus.fbk_valid && !stall()) begin bus.fbk_valid = 1'b1; bus.fbk_data = $urandom; end
    #1;
    if (bus.arg_valid && bus.arg_ready) begin
      k = arg_count % SAMPLES;
      check("arg_data", bus.arg_data, tb_arg[k]);
      check("en_phase", bus.en, (arg_count < TRAIN_ARGS) ? 1 : 0);
      x0 = int'(tb_arg[k][7]); x1 = int'(tb_arg[k][15]); cur_tgt = tb_tgt[k];
      sum = w0 * x0 + w1 * x1 + bias;
      res_hold = (const_mode || sum <= 0) ? 8'h00 : 8'hFF;
      in_eval = (arg_count >= TRAIN_ARGS);
      arg_count++;
      have_res = 1;
    end
    if (bus.res_valid && bus.res_ready) begin
      if (!in_eval) sb.push_back(16'(int'(cur_tgt) - int'(bus.res_data)));
      else if (bus.res_data !== cur_tgt) exp_mis++;
      have_res = 0;
    end
    if (bus.err_valid && bus.err_ready) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        exp_err = sb.pop_front();
        check("err_data", bus.err_data, exp_err);
      end
      if (bus.err_data == 16'hFF01) saw_ff01 = 1;
      if (bus.err_data == 16'h00FF) saw_00ff = 1;
      if (bus.err_data == 16'h0000) saw_zero = 1;
      if (bus.en && !const_mode) begin
        e = int'($signed(bus.err_data));
        delta = (e > 0) ? 1 : ((e < 0) ? -1 : 0);
        w0 += delta * x0; w1 += delta * x1; bias += delta;
      end
      err_count++;
      have_fbk = 1;
    end
    if (bus.fbk_valid && bus.fbk_ready) have_fbk = 0;
    arg_hold = bus.arg_valid && !bus.arg_ready; arg_prev = bus.arg_data;
    err_hold = bus.err_valid && !bus.err_ready; err_prev = bus.err_data;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_arg = '0; bus.ld_tgt = '0; bus.start = 0;
    bus.arg_ready = 0; bus.res_valid = 0; bus.res_data = '0;
    bus.err_ready = 0; bus.fbk_valid = 0; bus.fbk_data = '0;
    stall_pct = 0; const_mode = 0;
    model_clear();
    fork
      forever model_step();
    join_none

    repeat (2) tick_neg();
    check_all_zero("reset");
    rst = 1'b0;
    tick_neg();
    check("idle_ld_ready", bus.ld_ready, 1);
    check("idle_busy", bus.busy, 0);

    load(0, 16'h0000, 8'h00);
    load(1, 16'h00FF, 8'h00);
    load(2, 16'hFF00, 8'h00);
    load(3, 16'hFFFF, 8'hFF);

    // AND training, peers always ready
    model_clear();
    kick_start();
    wait_done(1000);
    check("and_cycles", cycles, RUN_CYCLES);
    check("and_mismatch_zero", bus.mismatches, 0);
    check("err_neg255_seen", saw_ff01, 1);
    check("err_pos255_seen", saw_00ff, 1);
    check("err_zero_seen", saw_zero, 1);
    check("done_ld_ready", bus.ld_ready, 1);

    // Random stalls, plus start and load attempts while busy
    stall_pct = 30;
    model_clear();
    kick_start();
    repeat (15) tick_neg();
    bus.start = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_addr = 2'd0; bus.ld_arg = 16'h1234; bus.ld_tgt = 8'h55;
    check("busy_ld_ready_0", bus.ld_ready, 0);
    tick_neg();
    bus.start = 1'b0;
    check("busy_ld_ready_1", bus.ld_ready, 0);
    tick_neg();
    bus.ld_valid = 1'b0;
    wait_done(5000);
    check("stall_mismatch_zero", bus.mismatches, 0);

    // Untrained constant-zero model
    stall_pct = 0;
    const_mode = 1;
    model_clear();
    kick_start();
    wait_done(1000);
    check("const_mismatch_one", bus.mismatches, 1);
    const_mode = 0;

    // Asynchronous reset while err_valid is up, then a clean rerun
    model_clear();
    kick_start();
    n = 0;
    while (bus.err_valid !== 1'b1 && n < 50) begin tick_neg(); n++; end
    check("bwd_err_valid", bus.err_valid, 1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_clear();
    tick_neg();
    rst = 1'b0;
    tick_neg();
    check("post_rst_ld_ready", bus.ld_ready, 1);
    model_clear();
    kick_start();
    wait_done(1000);
    check("rerun_cycles", cycles, RUN_CYCLES);
    check("rerun_mismatch_zero", bus.mismatches, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
